// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - imem request/response and IF/ID slot handshake bundle
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_inst;
    logic [ADDR_W-1:0] if_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_inst,
        output if_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_inst,
        input  if_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner, one-outstanding imem fetch, single-entry IF/ID slot; optional FETCH_PERF_EN counters
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    fetch_sequencer_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t            state;
    logic              redirect;
    logic              consume;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] target;

    always_comb begin
        redirect   = (pc_src == 2'b01) || (pc_src == 2'b10);
        raw_target = (pc_src == 2'b01) ? jump_addr : branch_addr;
        target     = raw_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};
        consume    = bus.if_valid & bus.if_ready & ~stall;
    end

    assign bus.imem_addr = pc;

    // imem_req is a registered pulse: it is raised on every transition into ISSUE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            bus.imem_req <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.if_inst  <= 32'h0;
            bus.if_pc    <= '0;
        end else begin
            bus.imem_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    state        <= S_ISSUE;
                    bus.imem_req <= 1'b1;
                end
                S_ISSUE: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= S_DRAIN;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (redirect) begin
                            pc           <= target;
                            state        <= S_ISSUE;
                            bus.imem_req <= 1'b1;
                        end else begin
                            bus.if_inst  <= bus.imem_rdata;
                            bus.if_pc    <= pc;
                            bus.if_valid <= 1'b1;
                            pc           <= pc + ADDR_W'(4);
                            state        <= S_HOLD;
                        end
                    end else if (redirect) begin
                        pc    <= target;
                        state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    // A redirect flushes the slot even if decode takes it the same cycle.
                    if (redirect) begin
                        bus.if_valid <= 1'b0;
                        pc           <= target;
                        state        <= S_ISSUE;
                        bus.imem_req <= 1'b1;
                    end else if (consume) begin
                        bus.if_valid <= 1'b0;
                        state        <= S_ISSUE;
                        bus.imem_req <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (bus.imem_rvalid) begin
                        state        <= S_ISSUE;
                        bus.imem_req <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (consume) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (bus.if_valid && !consume) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed cycle-exact bench for fetch_sequencer with a variable-latency imem model
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_src;
    logic [31:0] jump_addr;
    logic [31:0] branch_addr;
    logic        stall;
    logic        if_ready_drv;
    logic [31:0] pc;
    logic        m_rvalid;
    logic [31:0] m_rdata;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_checks;
    int n_pass;

    int          lat;
    bit          flush_on_reset;
    bit          pend;
    int          cnt;
    logic [31:0] p_addr;

    fetch_sequencer_if #(.ADDR_W(32)) bus ();

    assign bus.if_ready    = if_ready_drv;
    assign bus.imem_rvalid = m_rvalid;
    assign bus.imem_rdata  = m_rdata;

    fetch_sequencer #(
        .ADDR_W  (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_src      (pc_src),
        .jump_addr   (jump_addr),
        .branch_addr (branch_addr),
        .stall       (stall),
        .pc          (pc),
        .bus         (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h0123_4567;
            32'h4:   mem_word = 32'h89AB_CDEF;
            default: mem_word = 32'hA000_0000 | a;
        endcase
    endfunction

    // imem responder: a request seen in cycle k is answered with rvalid in cycle k+lat
    initial begin
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        pend     = 1'b0;
        cnt      = 0;
        p_addr   = 32'h0;
    end

    always @(posedge clk) begin
        #2;
        m_rvalid = 1'b0;
        if (!rst && flush_on_reset) pend = 1'b0;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt <= 0) begin
                m_rvalid = 1'b1;
                m_rdata  = mem_word(p_addr);
                pend     = 1'b0;
            end
        end
        if (bus.imem_req === 1'b1) begin
            pend   = 1'b1;
            cnt    = lat;
            p_addr = bus.imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its IDLE cycle with rst released; the next tick is ISSUE.
    task automatic reset_dut();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected 00000000", pc); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", bus.imem_req); else n_pass++;
        n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b expected 0", bus.if_valid); else n_pass++;
        n_checks++; if (bus.if_inst !== 32'h0) $display("FAIL reset_if_inst: got %h expected 00000000", bus.if_inst); else n_pass++;
        n_checks++; if (bus.if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h expected 00000000", bus.if_pc); else n_pass++;
        rst = 1'b1;
        #3;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL idle_req: got %b expected 0", bus.imem_req); else n_pass++;
        tick();
        n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %b expected 1", bus.imem_req); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL first_req_addr: got %h expected 00000000", bus.imem_addr); else n_pass++;
        tick();
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL req_single_cycle: got %b expected 0", bus.imem_req); else n_pass++;
    endtask

    task automatic test_sequential();
        lat = 1;
        if_ready_drv = 1'b1;
        reset_dut();
        tick();
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL seq_req0: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr); else n_pass++;
        tick();
        tick();
        n_checks++; if (bus.if_valid !== 1'b1) $display("FAIL seq_valid0: got %b expected 1", bus.if_valid); else n_pass++;
        n_checks++; if (bus.if_inst !== 32'h0123_4567 || bus.if_pc !== 32'h0) $display("FAIL seq_slot0: got inst=%h pc=%h expected inst=01234567 pc=00000000", bus.if_inst, bus.if_pc); else n_pass++;
        n_checks++; if (pc !== 32'h4) $display("FAIL seq_pc4: got %h expected 00000004", pc); else n_pass++;
        tick();
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) $display("FAIL seq_req1: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000004", bus.if_valid, bus.imem_req, bus.imem_addr); else n_pass++;
        tick();
        tick();
        n_checks++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h89AB_CDEF || bus.if_pc !== 32'h4) $display("FAIL seq_slot1: got valid=%b inst=%h pc=%h expected valid=1 inst=89abcdef pc=00000004", bus.if_valid, bus.if_inst, bus.if_pc); else n_pass++;
        n_checks++; if (pc !== 32'h8) $display("FAIL seq_pc8: got %h expected 00000008", pc); else n_pass++;
    endtask

    task automatic test_stall();
        lat = 1;
        if_ready_drv = 1'b1;
        stall = 1'b1;
        reset_dut();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h0123_4567 || bus.imem_req !== 1'b0) $display("FAIL stall_hold_%0d: got valid=%b inst=%h req=%b expected valid=1 inst=01234567 req=0", i, bus.if_valid, bus.if_inst, bus.imem_req); else n_pass++;
        end
        tick();
        stall = 1'b0;
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_stall !== 32'd3) $display("FAIL perf_stall: got %0d expected 3", perf_stall); else n_pass++;
        n_checks++; if (perf_fetched !== 32'd0) $display("FAIL perf_fetched_before: got %0d expected 0", perf_fetched); else n_pass++;
`endif
        tick();
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.if_valid !== 1'b0) $display("FAIL stall_release: got req=%b addr=%h valid=%b expected req=1 addr=00000004 valid=0", bus.imem_req, bus.imem_addr, bus.if_valid); else n_pass++;
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'd1) $display("FAIL perf_fetched_after: got %0d expected 1", perf_fetched); else n_pass++;
`endif
    endtask

    task automatic test_jump_drain();
        lat = 3;
        if_ready_drv = 1'b1;
        reset_dut();
        tick();
        tick();
        pc_src = 2'b01;
        jump_addr = 32'h100;
        tick();
        pc_src = 2'b00;
        n_checks++; if (pc !== 32'h100 || bus.imem_req !== 1'b0) $display("FAIL jump_drain_pc: got pc=%h req=%b expected pc=00000100 req=0", pc, bus.imem_req); else n_pass++;
        tick();
        n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL jump_drain_valid: got %b expected 0", bus.if_valid); else n_pass++;
        tick();
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) $display("FAIL jump_reissue: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000100", bus.if_valid, bus.imem_req, bus.imem_addr); else n_pass++;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_inst !== 32'hA000_0100) $display("FAIL jump_slot: got valid=%b pc=%h inst=%h expected valid=1 pc=00000100 inst=a0000100", bus.if_valid, bus.if_pc, bus.if_inst); else n_pass++;
    endtask

    task automatic test_branch_hold();
        lat = 1;
        if_ready_drv = 1'b0;
        reset_dut();
        tick();
        tick();
        tick();
        n_checks++; if (bus.if_valid !== 1'b1) $display("FAIL branch_pre_valid: got %b expected 1", bus.if_valid); else n_pass++;
        pc_src = 2'b10;
        branch_addr = 32'h202;
        tick();
        pc_src = 2'b11;
        jump_addr = 32'h300;
        branch_addr = 32'h400;
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) $display("FAIL branch_flush: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000200", bus.if_valid, bus.imem_req, bus.imem_addr); else n_pass++;
        tick();
        tick();
        n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200 || bus.if_inst !== 32'hA000_0200 || pc !== 32'h204) $display("FAIL pc_src11_seq: got valid=%b if_pc=%h inst=%h pc=%h expected valid=1 if_pc=00000200 inst=a0000200 pc=00000204", bus.if_valid, bus.if_pc, bus.if_inst, pc); else n_pass++;
        pc_src = 2'b00;
    endtask

    task automatic test_addr_wrap();
        lat = 1;
        if_ready_drv = 1'b0;
        reset_dut();
        pc_src = 2'b01;
        jump_addr = 32'hFFFF_FFFF;
        tick();
        pc_src = 2'b00;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req: got req=%b addr=%h expected req=1 addr=fffffffc", bus.imem_req, bus.imem_addr); else n_pass++;
        tick();
        tick();
        n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC || pc !== 32'h0) $display("FAIL wrap_pc: got valid=%b if_pc=%h pc=%h expected valid=1 if_pc=fffffffc pc=00000000", bus.if_valid, bus.if_pc, pc); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        lat = 3;
        if_ready_drv = 1'b1;
        reset_dut();
        flush_on_reset = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #3;
        n_checks++; if (m_rvalid !== 1'b1) $display("FAIL stale_rvalid_in_idle: got %b expected 1", m_rvalid); else n_pass++;
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0 || pc !== 32'h0 || bus.if_inst !== 32'h0 || bus.if_pc !== 32'h0) $display("FAIL midwait_reset_vals: got valid=%b req=%b pc=%h inst=%h if_pc=%h expected all zero", bus.if_valid, bus.imem_req, pc, bus.if_inst, bus.if_pc); else n_pass++;
        tick();
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL midwait_first_req: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000000", bus.if_valid, bus.imem_req, bus.imem_addr); else n_pass++;
        flush_on_reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        lat            = 1;
        flush_on_reset = 1'b1;
        rst            = 1'b0;
        pc_src         = 2'b00;
        jump_addr      = 32'h0;
        branch_addr    = 32'h0;
        stall          = 1'b0;
        if_ready_drv   = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_jump_drain();
        test_branch_hold();
        test_addr_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
